memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory pipeline stage fed by the execute-to-memory register. Performs loads/stores to data memory over a
//  req/ack bus of variable latency, stalls upstream while an access is outstanding, and registers results toward writeback.
//  Handles byte-wise access (lane select, store replication, load sign-extension) and word-alignment checks.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in WAIT without dmem_ack before abort with bus error (>=2)
//  CNT_W           9    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high; clears all state
//  m_dst_reg      in   5   destination register index
//  m_mem_read     in   1   load request
//  m_mem_write    in   1   store request
//  m_mem_byte     in   1   byte access (1) / word access (0)
//  m_reg_write    in   1   instruction writes register file
//  m_mem_to_reg   in   1   writeback data from memory (1) / ALU (0)
//  m_alu_result   in   32  ALU result; also effective address for loads/stores
//  m_store_data   in   32  store data (already forwarded)
//  m_stall        out  1   hold upstream stages; m_* inputs must stay stable while high
//  m_misaligned   out  1   1-cycle pulse: word access with m_alu_result[1:0]!=0
//  m_bus_error    out  1   1-cycle pulse: access timed out
//  dmem_req       out  1   request valid; held until dmem_ack
//  dmem_we        out  1   write enable (valid with dmem_req)
//  dmem_addr      out  32  word-aligned address {m_alu_result[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  write data
//  dmem_ack       in   1   access complete; dmem_rdata valid this cycle for reads
//  dmem_rdata     in   32  read data word
//  w_dst_reg      out  5   registered destination index
//  w_reg_write    out  1   registered register-file write enable
//  w_wb_data      out  32  registered writeback data
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counter=0, read-data latch=0. Reset mid-access drops dmem_req at once; no ack is awaited.
//  FSM IDLE->WAIT->DONE->IDLE.
//   IDLE: access = m_mem_read|m_mem_write. No access: m_stall=0, w_* load from m_* (w_wb_data=m_alu_result) every cycle.
//     Access, aligned: m_stall=1 (combinational), w_reg_write loads 0, dmem_* registered -> WAIT.
//     Access, word with addr[1:0]!=0: no bus cycle, m_misaligned pulse next cycle, w_reg_write loads 0, stay IDLE.
//   WAIT: dmem_req=1, dmem_* stable, m_stall=1, counter++ per cycle. On dmem_ack: latch dmem_rdata, drop req, ->DONE.
//     Counter reaching TIMEOUT_CYCLES without ack: drop req, m_bus_error pulse, mark suppress, ->DONE.
//   DONE: m_stall=0; w_* load (w_wb_data = m_mem_to_reg ? load_data : m_alu_result; w_reg_write = m_reg_write & ~suppress);
//     clear counter/suppress -> IDLE. Next instruction is evaluated in the following cycle.
//  Latency: access at cycle 0, dmem_req from cycle 1, ack earliest cycle 1 -> DONE cycle 2, w_* valid cycle 3.
//   m_stall high cycles 0..(ack cycle). Stores: same flow; w_reg_write follows m_reg_write (normally 0).
//  Read and write both set: treated as write; read ignored.
//  Byte access, lane = addr[1:0], little-endian: dmem_be = 4'b0001<<lane; dmem_wdata = {4{m_store_data[7:0]}};
//   load_data = sign-extended byte rdata[8*lane+7 -: 8]. Word: dmem_be=4'b1111, wdata=m_store_data, load_data=rdata.
//  dmem_ack outside WAIT is ignored. Error pulses are 1 cycle, registered, never simultaneous.
// STRUCTURE
//  Package memory_stage_pkg: FSM state typedef {IDLE,WAIT,DONE}, BE_WORD=4'b1111, BE_BYTE0=4'b0001, LANE_W=2.
//  Sub-module byte_lane_align (combinational): lane/size -> dmem_be, replicated wdata, extracted+extended load_data.
//  Top holds FSM, timeout counter, read-data latch and memory-to-writeback output registers.
// TESTING
//  1 Word load addr 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> w_wb_data=0xDEADBEEF, w_reg_write=1, stall 4 cyc.
//  2 Byte load addr 0x103, rdata 0x80112233 -> dmem_be=4'b1000, w_wb_data=0xFFFFFF80; addr 0x101 -> 0x00000022.
//  3 Byte store addr 0x102, data 0x000000AB -> dmem_we=1, dmem_be=4'b0100, dmem_wdata=0xABABABAB, w_reg_write=0.
//  4 Word load addr 0x102 -> no dmem_req, m_misaligned 1-cycle pulse, m_stall=0, w_reg_write=0.
//  5 Load with ack never given, TIMEOUT_CYCLES=4 -> req drops after 4 WAIT cycles, m_bus_error pulse, w_reg_write=0.
//  6 Reset asserted in WAIT -> dmem_req, m_stall, w_* all 0 immediately; late dmem_ack afterwards ignored.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam int         LANE_W   = 2;

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering: enables, store replication and load extraction.
module byte_lane_align
    import memory_stage_pkg::*;
(
    input  logic [LANE_W-1:0] lane,
    input  logic              is_byte,
    input  logic [31:0]       store_data,
    input  logic [31:0]       rdata,
    output logic [3:0]        be,
    output logic [31:0]       wdata,
    output logic [31:0]       load_data
);

    logic [7:0] rbyte;

    always_comb begin
        rbyte = rdata[{lane, 3'b000} +: 8];
        if (is_byte) begin
            be        = BE_BYTE0 << lane;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{rbyte[7]}}, rbyte};
        end else begin
            be        = BE_WORD;
            wdata     = store_data;
            load_data = rdata;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data-bus access FSM with timeout, alignment check
// and registered results toward writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  m_dst_reg,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic        m_mem_byte,
    input  logic        m_reg_write,
    input  logic        m_mem_to_reg,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_store_data,
    output logic        m_stall,
    output logic        m_misaligned,
    output logic        m_bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  w_dst_reg,
    output logic        w_reg_write,
    output logic [31:0] w_wb_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sup_q, sup_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        wdst_q, wdst_d;
    logic              wrw_q, wrw_d;
    logic [31:0]       wwb_q, wwb_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              access;
    logic              misal;
    logic              stall;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       load_c;

    byte_lane_align u_align (
        .lane       (m_alu_result[LANE_W-1:0]),
        .is_byte    (m_mem_byte),
        .store_data (m_store_data),
        .rdata      (rdata_q),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_c)
    );

    assign access = m_mem_read | m_mem_write;
    assign misal  = ~m_mem_byte & (m_alu_result[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sup_d   = sup_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wdst_d  = wdst_q;
        wrw_d   = wrw_q;
        wwb_d   = wwb_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wdst_d = m_dst_reg;
                wwb_d  = m_alu_result;
                if (!access) begin
                    wrw_d = m_reg_write;
                end else if (misal) begin
                    wrw_d = 1'b0;
                    mis_d = 1'b1;
                end else begin
                    wrw_d   = 1'b0;
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = m_mem_write;
                    addr_d  = {m_alu_result[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    cnt_d   = '0;
                    sup_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    sup_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                wdst_d  = m_dst_reg;
                wwb_d   = m_mem_to_reg ? load_c : m_alu_result;
                wrw_d   = m_reg_write & ~sup_q;
                cnt_d   = '0;
                sup_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sup_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wdst_q  <= '0;
            wrw_q   <= 1'b0;
            wwb_q   <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sup_q   <= sup_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wdst_q  <= wdst_d;
            wrw_q   <= wrw_d;
            wwb_q   <= wwb_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Stall is combinational, so it must be masked while reset is held.
    assign m_stall      = stall & ~reset;
    assign m_misaligned = mis_q;
    assign m_bus_error  = berr_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign w_dst_reg    = wdst_q;
    assign w_reg_write  = wrw_q;
    assign w_wb_data    = wwb_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus
// randomized traffic against a word-array memory model.
module tb_memory_stage;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  m_dst_reg;
    logic        m_mem_read, m_mem_write, m_mem_byte;
    logic        m_reg_write, m_mem_to_reg;
    logic [31:0] m_alu_result, m_store_data;
    logic        m_stall, m_misaligned, m_bus_error;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  w_dst_reg;
    logic        w_reg_write;
    logic [31:0] w_wb_data;

    memory_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .m_dst_reg(m_dst_reg), .m_mem_read(m_mem_read),
        .m_mem_write(m_mem_write), .m_mem_byte(m_mem_byte),
        .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
        .m_alu_result(m_alu_result), .m_store_data(m_store_data),
        .m_stall(m_stall), .m_misaligned(m_misaligned),
        .m_bus_error(m_bus_error),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .w_dst_reg(w_dst_reg), .w_reg_write(w_reg_write),
        .w_wb_data(w_wb_data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:15];

    int          o_req_cycles, o_stall_cnt;
    logic [3:0]  o_be;
    logic        o_we, o_berr, o_berr_after, o_mis, o_mis_after, o_stall_done;
    logic [31:0] o_wdata, o_addr, o_wwb;
    logic        o_wrw;
    logic [4:0]  o_wdst;

    function automatic logic [3:0] exp_be(input logic bt, input logic [31:0] a);
        return bt ? 4'(1 << (a % 4)) : 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic bt, input logic [31:0] sd);
        return bt ? (sd & 32'hFF) * 32'h01010101 : sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic bt, input logic [31:0] a,
                                             input logic [31:0] word);
        logic [7:0] b;
        if (!bt) return word;
        b = 8'((word >> (8 * (a % 4))) & 32'hFF);
        return 32'($signed(b));
    endfunction

    task automatic set_idle();
        m_dst_reg = 0; m_mem_read = 0; m_mem_write = 0; m_mem_byte = 0;
        m_reg_write = 0; m_mem_to_reg = 0; m_alu_result = 0; m_store_data = 0;
    endtask

    // Presents one instruction, acts as the memory (acks on WAIT cycle ack_n,
    // 0 = never) and records what the DUT showed.
    task automatic drive_access(input logic rd, input logic wr, input logic bt,
                                input logic rw, input logic m2r, input logic [4:0] dst,
                                input logic [31:0] addr, input logic [31:0] sd,
                                input int ack_n);
        int k;
        bit fin;
        logic [3:0] be_m;
        logic [31:0] wd_m;
        be_m = exp_be(bt, addr);
        wd_m = exp_wdata(bt, sd);
        o_req_cycles = 0; o_stall_cnt = 0; o_be = 0; o_we = 0; o_wdata = 0;
        o_addr = 0; o_berr = 0; o_berr_after = 0; o_mis = 0; o_mis_after = 0;
        o_stall_done = 0;
        @(posedge clock); #1;
        m_mem_read = rd; m_mem_write = wr; m_mem_byte = bt; m_reg_write = rw;
        m_mem_to_reg = m2r; m_dst_reg = dst; m_alu_result = addr; m_store_data = sd;
        dmem_ack = 0;
        @(negedge clock);
        if (m_stall) o_stall_cnt++;
        @(posedge clock); #1;
        if (!dmem_req) begin
            o_mis = m_misaligned; o_wrw = w_reg_write; o_wdst = w_dst_reg;
            o_wwb = w_wb_data;
            set_idle();
            @(posedge clock); #1;
            o_mis_after = m_misaligned;
            return;
        end
        o_addr = dmem_addr; o_be = dmem_be; o_we = dmem_we; o_wdata = dmem_wdata;
        k = 1; fin = 0;
        while (!fin) begin
            if (k == ack_n) begin
                dmem_ack = 1;
                dmem_rdata = mem[addr[5:2]];
                if (wr)
                    for (int b = 0; b < 4; b++)
                        if (be_m[b]) mem[addr[5:2]][8*b +: 8] = wd_m[8*b +: 8];
            end
            @(negedge clock);
            if (m_stall) o_stall_cnt++;
            @(posedge clock); #1;
            dmem_ack = 0;
            if (!dmem_req) fin = 1;
            else if (k >= TO + 4) fin = 1;
            else k++;
        end
        o_req_cycles = k;
        o_berr = m_bus_error; o_stall_done = m_stall; o_mis = m_misaligned;
        @(posedge clock); #1;
        o_wrw = w_reg_write; o_wdst = w_dst_reg; o_wwb = w_wb_data;
        o_berr_after = m_bus_error;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        m_mem_read = 1; m_alu_result = 32'h100;
        dmem_ack = 0; dmem_rdata = 0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (m_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", m_stall); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        total++; if ({w_reg_write, w_dst_reg, w_wb_data} !== 38'd0) begin bad++; $display("FAIL reset_w got=%b/%h/%h exp=0", w_reg_write, w_dst_reg, w_wb_data); end
        total++; if ({m_misaligned, m_bus_error, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 71'd0) begin bad++; $display("FAIL reset_misc got nonzero bus/err outputs"); end
        set_idle();
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_word_load();
        mem[0] = 32'hDEADBEEF;
        drive_access(1, 0, 0, 1, 1, 5'd7, 32'h100, 32'h0, 3);
        total++; if (o_addr !== 32'h100) begin bad++; $display("FAIL wl_addr got=%h exp=100", o_addr); end
        total++; if (o_be !== 4'hF || o_we !== 1'b0) begin bad++; $display("FAIL wl_be_we got=%h/%b exp=f/0", o_be, o_we); end
        total++; if (o_stall_cnt != 4) begin bad++; $display("FAIL wl_stall got=%0d exp=4", o_stall_cnt); end
        total++; if (o_req_cycles != 3) begin bad++; $display("FAIL wl_req got=%0d exp=3", o_req_cycles); end
        total++; if (o_stall_done !== 1'b0) begin bad++; $display("FAIL wl_stall_done got=%b exp=0", o_stall_done); end
        total++; if (o_wwb !== 32'hDEADBEEF) begin bad++; $display("FAIL wl_wb got=%h exp=deadbeef", o_wwb); end
        total++; if (o_wrw !== 1'b1 || o_wdst !== 5'd7) begin bad++; $display("FAIL wl_w got=%b/%0d exp=1/7", o_wrw, o_wdst); end
    endtask

    task automatic test_byte_load();
        mem[0] = 32'h80112233;
        drive_access(1, 0, 1, 1, 1, 5'd3, 32'h103, 32'h0, 1);
        total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL bl3_be got=%b exp=1000", o_be); end
        total++; if (o_wwb !== 32'hFFFFFF80) begin bad++; $display("FAIL bl3_wb got=%h exp=ffffff80", o_wwb); end
        drive_access(1, 0, 1, 1, 1, 5'd4, 32'h101, 32'h0, 2);
        total++; if (o_be !== 4'b0010) begin bad++; $display("FAIL bl1_be got=%b exp=0010", o_be); end
        total++; if (o_wwb !== 32'h00000022) begin bad++; $display("FAIL bl1_wb got=%h exp=00000022", o_wwb); end
    endtask

    task automatic test_byte_store();
        drive_access(0, 1, 1, 0, 0, 5'd0, 32'h102, 32'h000000AB, 2);
        total++; if (o_we !== 1'b1) begin bad++; $display("FAIL bs_we got=%b exp=1", o_we); end
        total++; if (o_be !== 4'b0100) begin bad++; $display("FAIL bs_be got=%b exp=0100", o_be); end
        total++; if (o_wdata !== 32'hABABABAB) begin bad++; $display("FAIL bs_wdata got=%h exp=abababab", o_wdata); end
        total++; if (o_wrw !== 1'b0) begin bad++; $display("FAIL bs_wrw got=%b exp=0", o_wrw); end
    endtask

    task automatic test_misaligned();
        drive_access(1, 0, 0, 1, 1, 5'd9, 32'h102, 32'h0, 1);
        total++; if (o_req_cycles != 0) begin bad++; $display("FAIL mis_req got=%0d exp=0", o_req_cycles); end
        total++; if (o_stall_cnt != 0) begin bad++; $display("FAIL mis_stall got=%0d exp=0", o_stall_cnt); end
        total++; if (o_mis !== 1'b1 || o_mis_after !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b%b exp=10", o_mis, o_mis_after); end
        total++; if (o_wrw !== 1'b0) begin bad++; $display("FAIL mis_wrw got=%b exp=0", o_wrw); end
    endtask

    task automatic test_timeout();
        drive_access(1, 0, 0, 1, 1, 5'd5, 32'h104, 32'h0, 0);
        total++; if (o_req_cycles != TO) begin bad++; $display("FAIL to_req got=%0d exp=%0d", o_req_cycles, TO); end
        total++; if (o_berr !== 1'b1 || o_berr_after !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b%b exp=10", o_berr, o_berr_after); end
        total++; if (o_mis !== 1'b0) begin bad++; $display("FAIL to_mis got=%b exp=0", o_mis); end
        total++; if (o_wrw !== 1'b0) begin bad++; $display("FAIL to_wrw got=%b exp=0", o_wrw); end
        total++; if (o_stall_cnt != TO + 1) begin bad++; $display("FAIL to_stall got=%0d exp=%0d", o_stall_cnt, TO + 1); end
    endtask

    task automatic test_reset_in_wait();
        @(posedge clock); #1;
        m_mem_read = 1; m_reg_write = 1; m_mem_to_reg = 1;
        m_dst_reg = 5'd12; m_alu_result = 32'h108;
        @(posedge clock); #1;
        @(posedge clock); #1;
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rw_pre_req got=%b exp=1", dmem_req); end
        reset = 1;
        set_idle();
        #1;
        total++; if (dmem_req !== 1'b0 || m_stall !== 1'b0) begin bad++; $display("FAIL rw_req_stall got=%b%b exp=00", dmem_req, m_stall); end
        total++; if ({w_reg_write, w_dst_reg, w_wb_data} !== 38'd0) begin bad++; $display("FAIL rw_w got=%b/%h/%h exp=0", w_reg_write, w_dst_reg, w_wb_data); end
        @(negedge clock);
        reset = 0;
        m_reg_write = 1; m_mem_to_reg = 1; m_alu_result = 32'h12345678; m_dst_reg = 5'd2;
        @(posedge clock); #1;
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        @(posedge clock); #1;
        dmem_ack = 0;
        @(posedge clock); #1;
        total++; if (dmem_req !== 1'b0 || m_stall !== 1'b0 || m_bus_error !== 1'b0) begin bad++; $display("FAIL rw_late_ack got=%b%b%b exp=000", dmem_req, m_stall, m_bus_error); end
        total++; if (w_wb_data !== 32'h12345678 || w_reg_write !== 1'b1) begin bad++; $display("FAIL rw_after_wb got=%h/%b exp=12345678/1", w_wb_data, w_reg_write); end
        set_idle();
    endtask

    task automatic test_random();
        int op, ack_n;
        logic rd, wr, bt, rw, m2r, acc, mis;
        logic [4:0] dst;
        logic [31:0] addr, sd, word, e_wb;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            rd = (op == 1) || (op == 3);
            wr = (op >= 2);
            bt = 1'($urandom_range(0, 1));
            addr = 32'h100 + $urandom_range(0, 63);
            if (!bt && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            sd = $urandom;
            dst = 5'($urandom);
            rw = (op == 0) ? 1'($urandom_range(0, 1)) : (rd && !wr);
            m2r = rd && !wr;
            ack_n = $urandom_range(1, TO);
            acc = rd | wr;
            mis = acc && !bt && (addr % 4 != 0);
            word = mem[addr[5:2]];
            e_wb = (acc && !mis && m2r) ? exp_load(bt, addr, word) : addr;
            drive_access(rd, wr, bt, rw, m2r, dst, addr, sd, ack_n);
            total++;
            if (o_req_cycles != ((acc && !mis) ? ack_n : 0) ||
                o_stall_cnt != ((acc && !mis) ? ack_n + 1 : 0)) begin
                bad++; $display("FAIL rnd%0d_timing req=%0d stall=%0d ack_n=%0d acc=%b mis=%b", it, o_req_cycles, o_stall_cnt, ack_n, acc, mis);
            end
            total++;
            if (o_mis !== mis || o_wrw !== ((acc) ? (!mis && rw) : rw) ||
                o_wdst !== dst || o_wwb !== e_wb) begin
                bad++; $display("FAIL rnd%0d_wb got=%b/%b/%0d/%h exp=%b/%0d/%h", it, o_mis, o_wrw, o_wdst, o_wwb, mis, dst, e_wb);
            end
            if (acc && !mis) begin
                total++;
                if (o_addr !== {addr[31:2], 2'b00} || o_be !== exp_be(bt, addr) ||
                    o_we !== wr || (wr && o_wdata !== exp_wdata(bt, sd))) begin
                    bad++; $display("FAIL rnd%0d_bus got=%h/%b/%b/%h exp=%h/%b/%b/%h", it, o_addr, o_be, o_we, o_wdata, {addr[31:2], 2'b00}, exp_be(bt, addr), wr, exp_wdata(bt, sd));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        set_idle();
        dmem_ack = 0;
        dmem_rdata = 0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
